cdc_hold_ctrl: RTL and testbench
================================

Name: cdc_hold_ctrl

Overview:
Source-domain controller for the N-bit `d_latch` holding register in the four-phase (req/ack) bus synchronizer. It accepts words over a valid/ready interface and pulses the latch enable to capture each word. It then runs the req/ack handshake toward the destination domain, with a synchronized ack, a timeout watchdog and a completed-transfer counter. The latch itself stays a separate instance; this block only sequences it.

Parameters:
N, 8, data bus width (matches `d_latch` N)
SYNC_STAGES, 2, flops in the ack synchronizer chain (legal 2..4)
TIMEOUT, 255, cycles allowed per handshake phase before timeout; 0 disables the watchdog
CNT_W, 16, width of the completed-transfer counter

Ports:
clk  input  1  single clock, source domain
rst  input  1  synchronous, active-high reset
in_data  input  N  word to transfer
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a word
latch_data  output  N  drives `d_latch` data input
latch_en  output  1  drives `d_latch` enable
req_out  output  1  handshake request to destination domain
ack_in  input  1  handshake acknowledge, asynchronous to clk
busy  output  1  transfer in progress (state != IDLE)
timeout_err  output  1  sticky watchdog error flag
err_clr  input  1  clears timeout_err
xfer_count  output  CNT_W  completed transfers, wraps modulo 2^CNT_W

Behaviour:
- All outputs are registered except in_ready, which is combinational: (state==IDLE) && !rst.
- Reset values: latch_data=0, latch_en=0, req_out=0, busy=0, timeout_err=0, xfer_count=0; sync chain cleared; state=IDLE. Reset mid-transfer aborts immediately, so req_out is low on the next cycle.
- ack_sync is ack_in after SYNC_STAGES flops. The FSM uses only ack_sync.
- FSM states and transitions:
  - IDLE: when in_valid && in_ready, register in_data into latch_data and go to LOAD.
  - LOAD (1 cycle): latch_en=1; then go to REQ.
  - REQ: latch_en=0, req_out=1. Wait for ack_sync==1, then go to ACKWAIT with req_out=0.
  - ACKWAIT: req_out=0. Wait for ack_sync==0, then increment xfer_count and go to IDLE.
- Timing for an accept edge at cycle T: latch_en is high only in cycle T+1 and req_out rises at T+2. This guarantees latch_en is low for ≥1 cycle before req rises and while req is high.
- latch_data changes only on the accept edge; it is stable in LOAD, REQ and ACKWAIT.
- Minimum transfer: 1 (accept) + 1 (LOAD) + 2·SYNC_STAGES + 2 cycles, with an immediate external ack.
- Watchdog (TIMEOUT>0):
  - Phase counter clears on entry to REQ and to ACKWAIT, and increments each cycle in those states.
  - In REQ, reaching TIMEOUT sets timeout_err, drops req_out and moves to ACKWAIT. The word is abandoned and xfer_count is not incremented.
  - In ACKWAIT, reaching TIMEOUT sets timeout_err, resets the counter and keeps waiting. The FSM never returns to IDLE while ack_sync is high.
- timeout_err clear rules:
  - err_clr clears timeout_err.
  - If err_clr and a new timeout occur in the same cycle, set wins.
- xfer_count wraps from 2^CNT_W−1 to 0 with no flag.
- in_valid while busy is ignored (in_ready=0); the upstream side must hold the word.
- ack_in glitches shorter than one synchronized sample have no defined effect. The destination is required to hold ack until req falls.

Decomposition:
- Package cdc_pkg holds:
  - the state enum (IDLE, LOAD, REQ, ACKWAIT) as a 2-bit typedef;
  - default SYNC_STAGES;
  - a function returning the watchdog counter width from TIMEOUT.
- Sub-module sync_ff_chain #(WIDTH, STAGES) is the generic multi-flop synchronizer used for ack_in, reusable for the destination-side req path.

Test Plan:
1. Reset, then in_data=8'hAA with in_valid=1 for one cycle, external ack responding 3 cycles after req. Required: latch_en high for exactly 1 cycle with latch_data=AA; req_out rises the next cycle; after ack_sync returns low, xfer_count=1 and in_ready=1.
2. Back-to-back words 8'h55 then 8'hF0, in_valid held high. Required: F0 accepted only after ACKWAIT completes; latch_data never changes while req_out=1; xfer_count=2.
3. TIMEOUT=8, ack tied low. Required: timeout_err=1 exactly 8 cycles after req_out rises; req_out drops; FSM returns to IDLE; xfer_count stays 0. Then pulse err_clr: timeout_err=0.
4. TIMEOUT=8, ack rises then stays high for 20 cycles. Required: timeout_err set in ACKWAIT; no return to IDLE until ack falls; xfer_count then increments by 1.
5. Assert rst while in REQ with ack high. Required: the next cycle has req_out=0, latch_en=0, busy=0, xfer_count=0 and timeout_err=0.
6. Preload xfer_count near wrap (CNT_W=4, 16 transfers). Required: xfer_count reads 0 after the 16th transfer.

Source files
------------

// File: rtl/cdc_pkg.sv
// Shared types and helpers for the source-domain side of the four-phase
// bus synchronizer.
//   state_e             : controller states (2-bit encoded)
//   DEFAULT_SYNC_STAGES : default depth of the ack synchronizer chain
//   wdogWidth()         : bit width needed by the per-phase watchdog counter
package cdc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    REQ     = 2'd2,
    ACKWAIT = 2'd3
  } state_e;

  localparam int DEFAULT_SYNC_STAGES = 2;

  // The watchdog counter only ever has to hold values up to TIMEOUT-1.
  // A disabled (0) or tiny timeout still gets a 1-bit counter so the
  // datapath never collapses to a zero-width vector.
  function automatic int wdogWidth(input int timeout);
    if (timeout <= 2) begin
      return 1;
    end
    return $clog2(timeout);
  endfunction

endpackage

// File: rtl/sync_ff_chain.sv
// Generic multi-flop synchronizer for signals crossing into the clk domain.
// Ports:
//   clk  : destination clock
//   rst  : synchronous active-high reset, clears every stage
//   d_i  : asynchronous input bits
//   q_o  : input bits after STAGES flops
module sync_ff_chain
  import cdc_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Plain shift chain; stage 0 is the only flop that may go metastable,
  // later stages give it time to resolve before the value is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/cdc_hold_ctrl.sv
// Source-domain controller for the d_latch holding register of the
// four-phase req/ack bus synchronizer. Accepts a word, pulses the latch
// enable, then runs the req/ack handshake with a per-phase watchdog and a
// completed-transfer counter.
// Ports:
//   clk, rst      : source clock, synchronous active-high reset
//   in_data/in_valid/in_ready : upstream word interface (in_ready is comb)
//   latch_data/latch_en       : drive the external d_latch
//   req_out/ack_in            : handshake toward the destination domain
//   busy          : a transfer is in progress
//   timeout_err   : sticky watchdog flag, cleared by err_clr
//   xfer_count    : completed transfers, wraps silently
module cdc_hold_ctrl
  import cdc_pkg::*;
#(
  parameter int N           = 8,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = 255,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     latch_data,
  output logic             latch_en,
  output logic             req_out,
  input  logic             ack_in,
  output logic             busy,
  output logic             timeout_err,
  input  logic             err_clr,
  output logic [CNT_W-1:0] xfer_count
);

  localparam int              WD_W        = wdogWidth(TIMEOUT);
  localparam int              TO_LAST_INT = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [WD_W-1:0] TO_LAST     = WD_W'(TO_LAST_INT);
  localparam bit              WDOG_EN     = (TIMEOUT > 0);

  state_e           state_q, state_d;
  logic [N-1:0]     latchData_q, latchData_d;
  logic             latchEn_q, reqOut_q, busy_q;
  logic             timeoutErr_q, timeoutErr_d;
  logic [CNT_W-1:0] xferCount_q, xferCount_d;
  logic [WD_W-1:0]  phaseCnt_q, phaseCnt_d;
  logic             abandon_q, abandon_d;
  logic             phaseTimeout;
  logic             ackSync;

  sync_ff_chain #(
    .WIDTH (1),
    .STAGES(SYNC_STAGES)
  ) u_ackSync (
    .clk(clk),
    .rst(rst),
    .d_i(ack_in),
    .q_o(ackSync)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. The watchdog fires when the phase counter has
  // counted TIMEOUT cycles in the current handshake phase; a real ack
  // always takes priority over a timeout in the same cycle.
  always_comb begin
    state_d      = state_q;
    phaseTimeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = REQ;
      end
      REQ: begin
        if (ackSync) begin
          state_d = ACKWAIT;
        end else if (WDOG_EN && (phaseCnt_q == TO_LAST)) begin
          phaseTimeout = 1'b1;
          state_d      = ACKWAIT;
        end
      end
      ACKWAIT: begin
        if (!ackSync) begin
          state_d = IDLE;
        end else if (WDOG_EN && (phaseCnt_q == TO_LAST)) begin
          phaseTimeout = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values. A word whose request phase timed out is marked
  // abandoned so that closing its ACKWAIT phase does not count it.
  always_comb begin
    latchData_d  = latchData_q;
    phaseCnt_d   = phaseCnt_q;
    abandon_d    = abandon_q;
    xferCount_d  = xferCount_q;
    timeoutErr_d = timeoutErr_q;

    if ((state_q == IDLE) && (state_d == LOAD)) begin
      latchData_d = in_data;
    end

    if ((state_d != state_q) || phaseTimeout) begin
      phaseCnt_d = '0;
    end else if ((state_q == REQ) || (state_q == ACKWAIT)) begin
      phaseCnt_d = phaseCnt_q + 1'b1;
    end

    if ((state_q == REQ) && phaseTimeout) begin
      abandon_d = 1'b1;
    end else if (state_d == IDLE) begin
      abandon_d = 1'b0;
    end

    if ((state_q == ACKWAIT) && (state_d == IDLE) && !abandon_q) begin
      xferCount_d = xferCount_q + 1'b1;
    end

    if (phaseTimeout) begin
      timeoutErr_d = 1'b1;
    end else if (err_clr) begin
      timeoutErr_d = 1'b0;
    end
  end

  // Output registers. latch_en/req_out/busy are decoded from the next
  // state so they line up exactly with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      latchData_q  <= '0;
      latchEn_q    <= 1'b0;
      reqOut_q     <= 1'b0;
      busy_q       <= 1'b0;
      timeoutErr_q <= 1'b0;
      xferCount_q  <= '0;
      phaseCnt_q   <= '0;
      abandon_q    <= 1'b0;
    end else begin
      latchData_q  <= latchData_d;
      latchEn_q    <= (state_d == LOAD);
      reqOut_q     <= (state_d == REQ);
      busy_q       <= (state_d != IDLE);
      timeoutErr_q <= timeoutErr_d;
      xferCount_q  <= xferCount_d;
      phaseCnt_q   <= phaseCnt_d;
      abandon_q    <= abandon_d;
    end
  end

  assign in_ready    = (state_q == IDLE) && !rst;
  assign latch_data  = latchData_q;
  assign latch_en    = latchEn_q;
  assign req_out     = reqOut_q;
  assign busy        = busy_q;
  assign timeout_err = timeoutErr_q;
  assign xfer_count  = xferCount_q;

endmodule

// File: tb/tb_cdc_hold_ctrl.sv
// Self-checking bench for cdc_hold_ctrl: directed scenarios followed by a
// randomized run, every cycle compared against a behavioural model.
module tb_cdc_hold_ctrl;

  localparam int N  = 8;
  localparam int SS = 2;
  localparam int TO = 8;
  localparam int CW = 4;

  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_REQ  = 2;
  localparam int P_ACKW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  latch_data;
  logic          latch_en;
  logic          req_out;
  logic          ack_in = 1'b0;
  logic          busy;
  logic          timeout_err;
  logic          err_clr = 1'b0;
  logic [CW-1:0] xfer_count;

  always #5 clk = ~clk;

  cdc_hold_ctrl #(
    .N(N), .SYNC_STAGES(SS), .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .latch_data(latch_data), .latch_en(latch_en),
    .req_out(req_out), .ack_in(ack_in), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr), .xfer_count(xfer_count)
  );

  int checks = 0;
  int fails  = 0;

  // Behavioural model: which handshake phase we are in, when that phase
  // started (edge number), the held word, the counter and the error flag.
  int           mPhase = P_IDLE;
  int           mEnter = 0;
  int           edgeNo = 0;
  logic [N-1:0] mData = '0;
  int           mCount = 0;
  bit           mErr = 1'b0;
  bit           mAbandon = 1'b0;
  bit           ackHist[$];

  // Destination-side responder configuration: 0 auto, 1 tied low, 2 manual.
  int ackMode = 1;
  int riseCfg = 0;
  int fallCfg = 0;
  int riseCnt = 0;
  int fallCnt = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", name, act, exp, edgeNo);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were present
  // just before that edge. ack_sync is the ack sample taken SS edges ago.
  task automatic modelStep();
    bit syncV;
    bit tout;
    if (rst) begin
      mPhase = P_IDLE; mData = '0; mCount = 0; mErr = 1'b0; mAbandon = 1'b0;
      ackHist.delete();
      return;
    end
    syncV = (ackHist.size() >= SS) ? ackHist[ackHist.size() - SS] : 1'b0;
    ackHist.push_back(ack_in);
    if (ackHist.size() > 8) void'(ackHist.pop_front());
    tout = 1'b0;
    case (mPhase)
      P_IDLE: if (in_valid) begin mData = in_data; mPhase = P_LOAD; end
      P_LOAD: begin mPhase = P_REQ; mEnter = edgeNo; end
      P_REQ: begin
        if (syncV) begin
          mPhase = P_ACKW; mEnter = edgeNo; mAbandon = 1'b0;
        end else if (TO > 0 && (edgeNo - mEnter) == TO) begin
          tout = 1'b1; mAbandon = 1'b1; mPhase = P_ACKW; mEnter = edgeNo;
        end
      end
      default: begin
        if (!syncV) begin
          if (!mAbandon) mCount = (mCount + 1) % (1 << CW);
          mPhase = P_IDLE;
        end else if (TO > 0 && (edgeNo - mEnter) == TO) begin
          tout = 1'b1; mEnter = edgeNo;
        end
      end
    endcase
    if (tout) mErr = 1'b1;
    else if (err_clr) mErr = 1'b0;
  endtask

  task automatic checkOutput();
    checkVal("latch_en",    32'(latch_en),    32'(mPhase == P_LOAD));
    checkVal("req_out",     32'(req_out),     32'(mPhase == P_REQ));
    checkVal("busy",        32'(busy),        32'(mPhase != P_IDLE));
    checkVal("latch_data",  32'(latch_data),  32'(mData));
    checkVal("xfer_count",  32'(xfer_count),  32'(mCount));
    checkVal("timeout_err", 32'(timeout_err), 32'(mErr));
  endtask

  function automatic int pickDelay(input int cfg, input int maxD);
    if (cfg >= 0) return cfg;
    if ($urandom_range(3, 0) == 0) return int'($urandom_range(maxD, 0));
    return int'($urandom_range(3, 0));
  endfunction

  // Four-phase destination: raise ack some cycles after req is seen, hold
  // it until req falls, drop it some cycles later.
  task automatic responder();
    if (ackMode == 1) begin
      ack_in = 1'b0;
    end else if (ackMode == 0) begin
      if (req_out && !ack_in) begin
        if (riseCnt <= 0) ack_in = 1'b1; else riseCnt--;
      end else begin
        riseCnt = pickDelay(riseCfg, 14);
      end
      if (!req_out && ack_in) begin
        if (fallCnt <= 0) ack_in = 1'b0; else fallCnt--;
      end else begin
        fallCnt = pickDelay(fallCfg, 22);
      end
    end
  endtask

  task automatic cycle();
    #1;
    checkVal("in_ready", 32'(in_ready), 32'(mPhase == P_IDLE && !rst));
    @(posedge clk);
    #1;
    edgeNo++;
    modelStep();
    checkOutput();
    responder();
  endtask

  task automatic applyStimulus();
    rst      = ($urandom_range(199, 0) == 0);
    in_valid = $urandom_range(1, 0) == 1;
    in_data  = N'($urandom);
    err_clr  = ($urandom_range(15, 0) == 0);
  endtask

  task automatic doReset();
    rst = 1'b1; in_valid = 1'b0; err_clr = 1'b0;
    cycle(); cycle();
    rst = 1'b0;
    checkVal("rst_busy",  32'(busy), 32'd0);
    checkVal("rst_count", 32'(xfer_count), 32'd0);
    checkVal("rst_req",   32'(req_out), 32'd0);
  endtask

  task automatic waitBusyLow(input int maxC, input string name);
    int n = 0;
    while (busy !== 1'b0 && n < maxC) begin cycle(); n++; end
    checkVal(name, 32'(busy), 32'd0);
  endtask

  task automatic waitReq(input logic want, input int maxC, input string name);
    int n = 0;
    while (req_out !== want && n < maxC) begin cycle(); n++; end
    checkVal(name, 32'(req_out), 32'(want));
  endtask

  task automatic acceptWord(input logic [N-1:0] w);
    in_data = w; in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    int n;
    int busyCnt;

    // Test 1: single word, ack 3 cycles after req.
    ackMode = 0; riseCfg = 3; fallCfg = 0;
    doReset();
    acceptWord(8'hAA);
    checkVal("t1_latch_en_hi", 32'(latch_en), 32'd1);
    checkVal("t1_latch_data",  32'(latch_data), 32'hAA);
    cycle();
    checkVal("t1_latch_en_lo", 32'(latch_en), 32'd0);
    checkVal("t1_req_rise",    32'(req_out), 32'd1);
    waitBusyLow(40, "t1_done");
    checkVal("t1_count", 32'(xfer_count), 32'd1);
    #1;
    checkVal("t1_in_ready", 32'(in_ready), 32'd1);

    // Test 2: back-to-back words with in_valid held high.
    doReset();
    in_data = 8'h55; in_valid = 1'b1;
    cycle();
    in_data = 8'hF0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      if (req_out === 1'b1) checkVal("t2_hold_55", 32'(latch_data), 32'h55);
      cycle(); n++;
    end
    checkVal("t2_first_done", 32'(busy), 32'd0);
    checkVal("t2_still_55",   32'(latch_data), 32'h55);
    cycle();
    checkVal("t2_took_F0", 32'(latch_data), 32'hF0);
    in_valid = 1'b0;
    waitBusyLow(40, "t2_done");
    checkVal("t2_count", 32'(xfer_count), 32'd2);

    // Test 3: ack tied low, request phase times out.
    ackMode = 1;
    doReset();
    acceptWord(8'h3C);
    waitReq(1'b1, 5, "t3_req_up");
    n = 0;
    while (timeout_err !== 1'b1 && n < 20) begin cycle(); n++; end
    checkVal("t3_tout_delay", 32'(n), 32'd8);
    checkVal("t3_req_drop",   32'(req_out), 32'd0);
    waitBusyLow(10, "t3_idle");
    checkVal("t3_count", 32'(xfer_count), 32'd0);
    err_clr = 1'b1; cycle(); err_clr = 1'b0;
    checkVal("t3_err_clr", 32'(timeout_err), 32'd0);

    // Test 4: ack held high long after req falls, ACKWAIT times out.
    ackMode = 2; ack_in = 1'b0;
    acceptWord(8'hC3);
    waitReq(1'b1, 5, "t4_req_up");
    ack_in = 1'b1;
    waitReq(1'b0, 10, "t4_req_down");
    busyCnt = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (busy === 1'b1) busyCnt++;
    end
    checkVal("t4_busy_hold", 32'(busyCnt), 32'd20);
    checkVal("t4_err_set",   32'(timeout_err), 32'd1);
    ack_in = 1'b0;
    waitBusyLow(10, "t4_done");
    checkVal("t4_count", 32'(xfer_count), 32'd1);

    // Test 5: reset while in REQ with ack high.
    acceptWord(8'h99);
    waitReq(1'b1, 5, "t5_req_up");
    ack_in = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    checkVal("t5_req",     32'(req_out), 32'd0);
    checkVal("t5_latch",   32'(latch_en), 32'd0);
    checkVal("t5_busy",    32'(busy), 32'd0);
    checkVal("t5_count",   32'(xfer_count), 32'd0);
    checkVal("t5_err",     32'(timeout_err), 32'd0);
    rst = 1'b0; ack_in = 1'b0;
    cycle(); cycle(); cycle();

    // Test 6: counter wrap after 2^CW transfers.
    ackMode = 0; riseCfg = 0; fallCfg = 0;
    doReset();
    for (int i = 0; i < 16; i++) begin
      acceptWord(N'($urandom));
      waitBusyLow(40, "t6_xfer");
      if (i == 14) checkVal("t6_count15", 32'(xfer_count), 32'd15);
    end
    checkVal("t6_wrap", 32'(xfer_count), 32'd0);

    // Randomized run with random ack delays, resets and error clears.
    riseCfg = -1; fallCfg = -1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 250) ackMode = 1;
      if (i % 500 == 300) ackMode = 0;
      applyStimulus();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
